imem_bus_master: RTL

//   Initiator for the shared 8-bit instruction-memory bus (cs/we/oe, 8-bit addr, bidirectional data).

---
 rtl/imem_bus_master_pkg.sv | 32 +++
 rtl/imem_bus_master_io.sv | 31 +++
 rtl/imem_bus_master.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/imem_bus_master_pkg.sv
// rtl/imem_bus_master_pkg.sv - shared widths, FSM encodings and parameter limits for the imem bus master
package imem_bus_master_pkg;

   localparam int IMEM_AW = 8;
   localparam int IMEM_DW = 8;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 7;
   localparam int TURN_CYC_MIN = 0;
   localparam int TURN_CYC_MAX = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TURN = 2'd1,
      WR   = 2'd2,
      RD   = 2'd3
   } state_t;

   // Out-of-range parameters saturate to the nearest legal value.
   function automatic logic [2:0] clamp_lat(input int v);
      if (v < READ_LAT_MIN)      return 3'(READ_LAT_MIN);
      else if (v > READ_LAT_MAX) return 3'(READ_LAT_MAX);
      else                       return 3'(v);
   endfunction

   function automatic logic [1:0] clamp_turn(input int v);
      if (v < TURN_CYC_MIN)      return 2'(TURN_CYC_MIN);
      else if (v > TURN_CYC_MAX) return 2'(TURN_CYC_MAX);
      else                       return 2'(v);
   endfunction

endpackage

// File: rtl/imem_bus_master_io.sv
// rtl/imem_bus_master_io.sv - registered tristate driver and read-data sample register for mem_data
module imem_bus_io
   import imem_bus_master_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               drive_en,
   input  logic [IMEM_DW-1:0] wdata,
   input  logic               sample_en,
   output logic [IMEM_DW-1:0] rdata,
   inout  wire  [IMEM_DW-1:0] mem_data
);

   logic               drive_q;
   logic [IMEM_DW-1:0] wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drive_q <= 1'b0;
         wdata_q <= '0;
         rdata   <= '0;
      end else begin
         drive_q <= drive_en;
         wdata_q <= wdata;
         if (sample_en) rdata <= mem_data;
      end
   end

   assign mem_data = drive_q ? wdata_q : {IMEM_DW{1'bz}};

endmodule

// File: rtl/imem_bus_master.sv
// rtl/imem_bus_master.sv - instruction-memory bus initiator with turnaround control
// Optional burst reads (req_len port) enabled by defining IMEM_BUS_BURST_EN.
module imem_bus_master
   import imem_bus_master_pkg::*;
#(
   parameter int READ_LAT = 1,
   parameter int TURN_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [IMEM_AW-1:0] req_addr,
   input  logic [IMEM_DW-1:0] req_wdata,
`ifdef IMEM_BUS_BURST_EN
   input  logic [2:0]         req_len,
`endif
   output logic               rsp_valid,
   output logic [IMEM_DW-1:0] rsp_rdata,
   output logic               mem_cs,
   output logic               mem_we,
   output logic               mem_oe,
   output logic [IMEM_AW-1:0] mem_addr,
   inout  wire  [IMEM_DW-1:0] mem_data
);

   localparam logic [2:0] RL_INIT   = clamp_lat(READ_LAT);
   localparam logic [1:0] TURN_INIT = clamp_turn(TURN_CYC);

   state_t             state, state_n;
   logic               last_rd, last_rd_n;
   logic [1:0]         turn_left, turn_n;
   logic [2:0]         wait_cnt, wait_n;
   logic [2:0]         beats_left, beats_n;
   logic [IMEM_AW-1:0] addr_q, addr_n;
   logic [IMEM_DW-1:0] wdata_q, wdata_n;
   logic [2:0]         len_in;
   logic               sample_en, rsp_valid_n, cs_n;

`ifdef IMEM_BUS_BURST_EN
   assign len_in = req_len;
`else
   assign len_in = 3'd0;
`endif

   always_comb begin
      state_n     = state;
      last_rd_n   = last_rd;
      turn_n      = turn_left;
      wait_n      = wait_cnt;
      beats_n     = beats_left;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      sample_en   = 1'b0;
      rsp_valid_n = 1'b0;
      case (state)
         IDLE: begin
            // Idle cycles after a read already count toward the turnaround.
            if (turn_left != 2'd0) turn_n = turn_left - 2'd1;
            if (req_valid && req_ready) begin
               addr_n  = req_addr;
               wdata_n = req_wdata;
               wait_n  = RL_INIT;
               beats_n = req_we ? 3'd0 : len_in;
               if (!req_we)                              state_n = RD;
               else if (last_rd && turn_left > 2'd1)     state_n = TURN;
               else                                      state_n = WR;
            end
         end
         TURN: begin
            if (turn_left > 2'd1) begin
               turn_n = turn_left - 2'd1;
            end else begin
               turn_n  = 2'd0;
               state_n = WR;
            end
         end
         WR: begin
            last_rd_n = 1'b0;
            state_n   = IDLE;
         end
         RD: begin
            if (wait_cnt != 3'd0) begin
               wait_n = wait_cnt - 3'd1;
            end else begin
               sample_en   = 1'b1;
               rsp_valid_n = 1'b1;
               if (beats_left != 3'd0) begin
                  beats_n = beats_left - 3'd1;
                  addr_n  = addr_q + 1'b1;
                  wait_n  = RL_INIT;
               end else begin
                  last_rd_n = 1'b1;
                  turn_n    = TURN_INIT;
                  state_n   = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign cs_n = (state_n == WR) || (state_n == RD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_rd    <= 1'b0;
         turn_left  <= 2'd0;
         wait_cnt   <= 3'd0;
         beats_left <= 3'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_oe     <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state      <= state_n;
         last_rd    <= last_rd_n;
         turn_left  <= turn_n;
         wait_cnt   <= wait_n;
         beats_left <= beats_n;
         addr_q     <= addr_n;
         wdata_q    <= wdata_n;
         req_ready  <= (state_n == IDLE);
         rsp_valid  <= rsp_valid_n;
         mem_cs     <= cs_n;
         mem_we     <= (state_n == WR);
         mem_oe     <= (state_n == RD);
         mem_addr   <= cs_n ? addr_n : '0;
      end
   end

   imem_bus_io u_io (
      .clk       (clk),
      .rst       (rst),
      .drive_en  (state_n == WR),
      .wdata     (wdata_n),
      .sample_en (sample_en),
      .rdata     (rsp_rdata),
      .mem_data  (mem_data)
   );

endmodule
